// File: rtl/validator_sched_pkg.sv
// Shared types and helpers for the validator scheduler.
// Provides data widths, the tag bundle and a saturating increment.
package validator_sched_pkg;

  localparam int TXN_W     = 128;
  localparam int HASH_W    = 128;
  localparam int SRC_MAX_W = 4;

  // src is sized for the largest supported requester count (16);
  // narrower configurations leave the upper bits at zero.
  typedef struct packed {
    logic                 tv;
    logic [SRC_MAX_W-1:0] src;
  } tag_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/validator_scheduler_rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
// Ports: clk, rst, en, req[N] in; one-hot gnt[N] and binary idx out.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [W-1:0] ptr;
  logic [W:0]   c;
  logic         found;

  // Walk from ptr upward, wrapping, and take the first requester.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 0; i < N; i++) begin
      c = {1'b0, ptr} + (W+1)'(i);
      if (c >= (W+1)'(N)) c = c - (W+1)'(N);
      if (en && !found && req[c[W-1:0]]) begin
        found          = 1'b1;
        gnt[c[W-1:0]]  = 1'b1;
        idx            = c[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (idx == W'(N-1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/validator_scheduler.sv
// Shares one validator pipeline between N_REQ sources round-robin.
// Ports: req_* in/out, val_* to/from validator, res_* out, stats, err.
module validator_scheduler
  import validator_sched_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int PIPE_LAT = 3,
  parameter  int CNT_W    = 16,
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*TXN_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   val_valid,
  output logic [TXN_W-1:0]       val_data,
  input  logic                   val_o_valid,
  input  logic [HASH_W-1:0]      val_o_hash,
  output logic                   res_valid,
  output logic [HASH_W-1:0]      res_hash,
  output logic [SRC_W-1:0]       res_src,
  output logic                   err_orphan,
  input  logic                   err_clr,
  output logic [CNT_W-1:0]       issue_cnt,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << CNT_W) - 64'd1);
  localparam int WC_W = $clog2(PIPE_LAT + 1);

  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] gidx;
  logic             issue;
  logic [SRC_W-1:0] src_q;
  tag_t             tag_q [PIPE_LAT];
  tag_t             last;
  logic             hit;
  logic             drop;
  logic             orphan;
  logic [WC_W-1:0]  wcnt;
  logic             warm;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .req (req_valid),
    .gnt (gnt),
    .idx (gidx)
  );

  assign issue     = |gnt;
  assign req_ready = gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_valid <= 1'b0;
      val_data  <= '0;
      src_q     <= '0;
    end else begin
      val_valid <= issue;
      if (issue) begin
        val_data <= req_data[int'(gidx)*TXN_W +: TXN_W];
        src_q    <= gidx;
      end
    end
  end

  // Stage 0 captures the issue register, so the last stage lines up
  // with the validator output PIPE_LAT cycles after val_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].tv  <= val_valid;
      tag_q[0].src <= SRC_MAX_W'(src_q);
      for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign last   = tag_q[PIPE_LAT-1];
  assign warm   = wcnt < WC_W'(PIPE_LAT);
  assign hit    = last.tv & val_o_valid;
  assign drop   = last.tv & ~val_o_valid;
  assign orphan = ~last.tv & val_o_valid & ~warm;

  // Validator outputs still in flight from before reset land here
  // untagged; the warm-up window keeps them from raising err_orphan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (warm) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hash  <= '0;
      res_src   <= '0;
    end else begin
      res_valid <= hit;
      if (hit) begin
        res_hash <= val_o_hash;
        res_src  <= last.src[SRC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_orphan <= 1'b0;
    end else if (orphan) begin
      err_orphan <= 1'b1;
    end else if (err_clr) begin
      err_orphan <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      pass_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (issue)
        issue_cnt <= CNT_W'(sat_inc(32'(issue_cnt), CNT_MAX));
      if (hit)
        pass_cnt  <= CNT_W'(sat_inc(32'(pass_cnt), CNT_MAX));
      if (drop)
        drop_cnt  <= CNT_W'(sat_inc(32'(drop_cnt), CNT_MAX));
    end
  end

endmodule

// File: tb/tb_validator_scheduler.sv
// Randomized bench for validator_scheduler with a transaction-level
// model: expected grants, result queue keyed by due cycle, counters.
module tb_validator_scheduler;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int CW  = 16;
  localparam int SW  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           err_clr = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*128-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           val_valid;
  logic [127:0]   val_data;
  logic           val_o_valid;
  logic [127:0]   val_o_hash;
  logic           res_valid;
  logic [127:0]   res_hash;
  logic [SW-1:0]  res_src;
  logic           err_orphan;
  logic [CW-1:0]  issue_cnt, pass_cnt, drop_cnt;

  validator_scheduler #(
    .N_REQ (N), .PIPE_LAT (LAT), .CNT_W (CW)
  ) dut (
    .clk (clk), .rst (rst), .en (en),
    .req_valid (req_valid), .req_data (req_data),
    .req_ready (req_ready),
    .val_valid (val_valid), .val_data (val_data),
    .val_o_valid (val_o_valid), .val_o_hash (val_o_hash),
    .res_valid (res_valid), .res_hash (res_hash),
    .res_src (res_src),
    .err_orphan (err_orphan), .err_clr (err_clr),
    .issue_cnt (issue_cnt), .pass_cnt (pass_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Validator stand-in: fixed latency, filters txns with bit 127 set.
  function automatic logic [127:0] hash_of(input logic [127:0] d);
    return {d[63:0], d[127:64]} ^ 128'hA5A5_0F0F_3C3C_9999_1234_5678_DEAD_BEEF;
  endfunction

  logic         vv [LAT] = '{default: 1'b0};
  logic [127:0] vd [LAT] = '{default: '0};
  logic         inject = 1'b0;

  always @(posedge clk) begin
    vv[0] <= val_valid;
    vd[0] <= val_data;
    for (int i = 1; i < LAT; i++) begin
      vv[i] <= vv[i-1];
      vd[i] <= vd[i-1];
    end
  end

  assign val_o_valid = (vv[LAT-1] && !vd[LAT-1][127]) || inject;
  assign val_o_hash  = inject ? 128'hBAD0 : hash_of(vd[LAT-1]);

  typedef struct {
    int           due;
    int           src;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   mptr = 0;
  int   since_rst = 0;
  int   m_issue = 0, m_pass = 0, m_drop = 0;
  logic m_err = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: inputs already driven; check grant, advance, check outputs.
  task automatic cycle();
    int           k;
    int           c;
    logic [N-1:0] eg;
    logic         orph;
    exp_t         e;
    #1;
    k  = -1;
    eg = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        c = (mptr + i) % N;
        if (k < 0 && req_valid[c]) k = c;
      end
    end
    if (k >= 0) eg[k] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(eg));
    orph = inject && (since_rst + 1 > LAT) &&
           !(q.size() > 0 && q[0].due == cyc + 1);
    if (k >= 0) begin
      q.push_back('{due: cyc + LAT + 2, src: k,
                    data: req_data[k*128 +: 128]});
      mptr    = (k + 1) % N;
      m_issue = sat(m_issue + 1);
    end
    @(posedge clk);
    cyc++;
    since_rst++;
    if (orph) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    @(negedge clk);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.data[127]) begin
        m_drop = sat(m_drop + 1);
        chk("res_valid_drop", 128'(res_valid), 128'(0));
      end else begin
        m_pass = sat(m_pass + 1);
        chk("res_valid", 128'(res_valid), 128'(1));
        chk("res_hash", res_hash, hash_of(e.data));
        chk("res_src", 128'(res_src), 128'(e.src));
      end
    end else begin
      chk("res_valid_idle", 128'(res_valid), 128'(0));
    end
    chk("issue_cnt", 128'(issue_cnt), 128'(m_issue));
    chk("pass_cnt", 128'(pass_cnt), 128'(m_pass));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    chk("err_orphan", 128'(err_orphan), 128'(m_err));
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_reqs(input logic allow_drop);
    logic [127:0] d;
    req_valid = N'($urandom);
    for (int s = 0; s < N; s++) begin
      d = rnd128();
      if (!allow_drop) d[127] = 1'b0;
      req_data[s*128 +: 128] = d;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_val_valid"}, 128'(val_valid), 128'(0));
    chk({tag, "_res_valid"}, 128'(res_valid), 128'(0));
    chk({tag, "_err"}, 128'(err_orphan), 128'(0));
    chk({tag, "_issue"}, 128'(issue_cnt), 128'(0));
    chk({tag, "_pass"}, 128'(pass_cnt), 128'(0));
    chk({tag, "_drop"}, 128'(drop_cnt), 128'(0));
  endtask

  task automatic do_reset();
    en  = 1'b0;
    req_valid = '0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mptr = 0;
    m_issue = 0;
    m_pass = 0;
    m_drop = 0;
    m_err = 1'b0;
    since_rst = 0;
  endtask

  initial begin
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    en  = 1'b1;

    // single source 2, unfiltered
    req_valid = 4'b0100;
    req_data[2*128 +: 128] = 128'h1;
    cycle();
    idle(7);

    // all sources continuously valid
    for (int i = 0; i < 8; i++) begin
      rand_reqs(1'b0);
      req_valid = '1;
      cycle();
    end
    idle(6);

    // middle of three back-to-back txns is filtered
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0010;
      req_data[1*128 +: 128] = rnd128();
      req_data[1*128 + 127] = (i == 1);
      cycle();
    end
    idle(6);

    // random traffic with an enable gap
    for (int i = 0; i < 30; i++) begin
      rand_reqs(1'b1);
      en = !(i >= 12 && i < 16);
      cycle();
    end
    en = 1'b1;
    idle(6);

    // orphan after warm-up, clear, and set-wins-over-clear
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    inject = 1'b1;
    err_clr = 1'b1;
    cycle();
    inject = 1'b0;
    cycle();
    cycle();
    err_clr = 1'b0;
    cycle();

    // reset with traffic in flight, orphan inside warm-up
    for (int i = 0; i < 10; i++) begin
      rand_reqs(1'b1);
      cycle();
    end
    do_reset();
    en = 1'b1;
    idle(1);
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    idle(4);
    for (int i = 0; i < 20; i++) begin
      rand_reqs(1'b1);
      cycle();
    end

    // saturation of the counters
    for (int i = 0; i < CMAX + 4; i++) begin
      rand_reqs(1'b1);
      req_valid = '1;
      cycle();
    end
    idle(6);
    chk("issue_sat", 128'(issue_cnt), 128'(CMAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
